// File: rtl/fft_r22sdf_tw_sched.sv
// Sample sequencer and twiddle-address scheduler for one R2^2 SDF stage pair.
// Optional sticky protocol-error flag err_o is enabled by defining FFT_TW_SCHED_ERR_EN.
module fft_r22sdf_tw_sched #(
   parameter int unsigned FFT_N        = 1024,
   parameter int unsigned NLOG2        = 10,
   parameter int unsigned STAGE        = 0,
   parameter int unsigned DRAIN_CYCLES = 8
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             valid_i,
   output logic [NLOG2-1:0] ctr_o,
   output logic [NLOG2-1:0] tw_addr_o,
   output logic             tw_valid_o,
   output logic             frame_start_o,
   output logic             flush_o,
   output logic             done_o,
`ifdef FFT_TW_SCHED_ERR_EN
   output logic             err_o,
`endif
   output logic             busy_o
);

   localparam int unsigned LOGM = NLOG2 - 2 * STAGE;
   localparam int unsigned DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   // Low bits of the local index that select the position inside a quadrant.
   localparam logic [NLOG2-1:0] QMASK = NLOG2'((1 << (LOGM - 2)) - 1);
   localparam logic [NLOG2-1:0] LAST  = NLOG2'(FFT_N - 1);
   localparam logic [NLOG2-1:0] ONE   = NLOG2'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           r_state;
   logic [NLOG2-1:0] r_cnt;
   logic [NLOG2-1:0] r_acc;
   logic             r_stop_pend;
   logic [DW-1:0]    r_drain;
   logic [NLOG2-1:0] r_ctr;
   logic [NLOG2-1:0] r_tw;
   logic             r_tw_valid;
   logic             r_frame_start;
   logic             r_flush;
   logic             r_done;
   logic             r_busy;

   logic [1:0]       w_q;
   logic [1:0]       w_f;
   logic [NLOG2-1:0] w_step;
   logic [NLOG2-1:0] w_acc_use;
   logic             w_q_first;
   logic             w_last;
   logic             w_stop_now;

   assign w_q = 2'(r_cnt >> (LOGM - 2));

   // Quadrants 1 and 2 are swapped relative to natural order (bit-reversed factor).
   always_comb begin
      w_f = 2'd0;
      unique case (w_q)
         2'd0: w_f = 2'd0;
         2'd1: w_f = 2'd2;
         2'd2: w_f = 2'd1;
         2'd3: w_f = 2'd3;
         default: w_f = 2'd0;
      endcase
   end

   assign w_step     = NLOG2'(w_f) << (2 * STAGE);
   assign w_q_first  = ((r_cnt & QMASK) == '0);
   assign w_acc_use  = w_q_first ? '0 : r_acc;
   assign w_last     = (r_cnt == LAST);
   assign w_stop_now = r_stop_pend | stop_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_acc         <= '0;
         r_stop_pend   <= 1'b0;
         r_drain       <= '0;
         r_ctr         <= '0;
         r_tw          <= '0;
         r_tw_valid    <= 1'b0;
         r_frame_start <= 1'b0;
         r_flush       <= 1'b0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_tw_valid    <= 1'b0;
         r_frame_start <= 1'b0;
         r_done        <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start_i) begin
                  r_state     <= StRun;
                  r_busy      <= 1'b1;
                  r_cnt       <= '0;
                  r_acc       <= '0;
                  r_stop_pend <= 1'b0;
               end
            end
            StRun: begin
               if (stop_i) r_stop_pend <= 1'b1;
               if (valid_i) begin
                  r_ctr         <= r_cnt;
                  r_tw          <= w_acc_use;
                  r_tw_valid    <= 1'b1;
                  r_frame_start <= (r_cnt == '0);
                  if (w_last && w_stop_now) begin
                     r_state     <= StDrain;
                     r_flush     <= 1'b1;
                     r_cnt       <= '0;
                     r_acc       <= '0;
                     r_stop_pend <= 1'b0;
                     r_drain     <= DW'(DRAIN_CYCLES - 1);
                  end else begin
                     r_cnt <= r_cnt + ONE;
                     r_acc <= w_acc_use + w_step;
                  end
               end
            end
            StDrain: begin
               if (r_drain == '0) begin
                  r_state <= StIdle;
                  r_flush <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain <= r_drain - DW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef FFT_TW_SCHED_ERR_EN
   logic r_err;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if ((valid_i && (r_state != StRun)) || (start_i && (r_state != StIdle))) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`endif

   assign ctr_o         = r_ctr;
   assign tw_addr_o     = r_tw;
   assign tw_valid_o    = r_tw_valid;
   assign frame_start_o = r_frame_start;
   assign flush_o       = r_flush;
   assign done_o        = r_done;
   assign busy_o        = r_busy;

endmodule

// File: tb/tb_fft_r22sdf_tw_sched.sv
// Self-checking bench: a 16-point stage-0 instance and a 64-point stage-1 instance,
// with a table of spec twiddle sequences feeding per-instance scoreboards.
module tb_fft_r22sdf_tw_sched;

   typedef struct {
      int c;
      int tw16;
      int tw64;
   } vec_t;

   typedef struct {
      int c;
      int tw;
   } exp_t;

   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MDrain = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n16, start16, stop16, valid16;
   logic [3:0] ctr16, tw16;
   logic       tv16, fs16, fl16, dn16, bz16;
   logic       rst_n64, start64, stop64, valid64;
   logic [5:0] ctr64, tw64;
   logic       tv64, fs64, fl64, dn64, bz64;
`ifdef FFT_TW_SCHED_ERR_EN
   logic       err16, err64;
`endif

   fft_r22sdf_tw_sched #(
      .FFT_N(16), .NLOG2(4), .STAGE(0), .DRAIN_CYCLES(8)
   ) u_dut16 (
      .clk_i(clk), .rst_n(rst_n16), .start_i(start16), .stop_i(stop16), .valid_i(valid16),
      .ctr_o(ctr16), .tw_addr_o(tw16), .tw_valid_o(tv16), .frame_start_o(fs16),
      .flush_o(fl16), .done_o(dn16),
`ifdef FFT_TW_SCHED_ERR_EN
      .err_o(err16),
`endif
      .busy_o(bz16)
   );

   fft_r22sdf_tw_sched #(
      .FFT_N(64), .NLOG2(6), .STAGE(1), .DRAIN_CYCLES(3)
   ) u_dut64 (
      .clk_i(clk), .rst_n(rst_n64), .start_i(start64), .stop_i(stop64), .valid_i(valid64),
      .ctr_o(ctr64), .tw_addr_o(tw64), .tw_valid_o(tv64), .frame_start_o(fs64),
      .flush_o(fl64), .done_o(dn64),
`ifdef FFT_TW_SCHED_ERR_EN
      .err_o(err64),
`endif
      .busy_o(bz64)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t tbl[16];
   exp_t q16[$];
   exp_t q64[$];
   exp_t e16, e64;

   int m16 = MIdle, m_c16 = 0;
   bit m_pend = 1'b0;
   bit m64run = 1'b0;
   int m_c64 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboards: every registered output beat must match the oldest accepted sample.
   always @(negedge clk) begin
      if (tv16 === 1'b1) begin
         if (q16.size() == 0) begin
            chk("sb16_unexpected", 1, 0);
         end else begin
            e16 = q16.pop_front();
            chk("ctr16", ctr16, e16.c);
            chk("tw16", tw16, e16.tw);
            chk("fs16", fs16, (e16.c == 0));
         end
      end else begin
         chk("fs16_idle", fs16, 0);
      end
      if (tv64 === 1'b1) begin
         if (q64.size() == 0) begin
            chk("sb64_unexpected", 1, 0);
         end else begin
            e64 = q64.pop_front();
            chk("ctr64", ctr64, e64.c);
            chk("tw64", tw64, e64.tw);
            chk("fs64", fs64, (e64.c == 0));
         end
      end
   end

   task automatic cyc16(input bit st, input bit sp, input bit v);
      bit acc;
      start16 = st;
      stop16  = sp;
      valid16 = v;
      acc = rst_n16 && (m16 == MRun) && v;
      if (acc) q16.push_back('{c: m_c16, tw: tbl[m_c16].tw16});
      if (!rst_n16) begin
         m16 = MIdle; m_c16 = 0; m_pend = 1'b0;
      end else if (m16 == MIdle && st) begin
         m16 = MRun; m_c16 = 0; m_pend = 1'b0;
      end else if (m16 == MRun) begin
         if (sp) m_pend = 1'b1;
         if (acc) begin
            if (m_c16 == 15 && m_pend) begin
               m16 = MDrain; m_c16 = 0; m_pend = 1'b0;
            end else begin
               m_c16 = (m_c16 + 1) % 16;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("tv16_follows_valid", tv16, acc);
   endtask

   task automatic cyc64(input bit st, input bit v);
      bit acc;
      start64 = st;
      valid64 = v;
      acc = rst_n64 && m64run && v;
      if (acc) begin
         q64.push_back('{c: m_c64, tw: tbl[m_c64 % 16].tw64});
         m_c64 = (m_c64 + 1) % 64;
      end else if (rst_n64 && !m64run && st) begin
         m64run = 1'b1;
         m_c64  = 0;
      end
      @(posedge clk);
      #1;
      chk("tv64_follows_valid", tv64, acc);
   endtask

   task automatic zero16(input string name);
      chk({name, "_ctr"}, ctr16, 0);
      chk({name, "_tw"}, tw16, 0);
      chk({name, "_tv"}, tv16, 0);
      chk({name, "_fs"}, fs16, 0);
      chk({name, "_flush"}, fl16, 0);
      chk({name, "_done"}, dn16, 0);
      chk({name, "_busy"}, bz16, 0);
   endtask

   task automatic seq16();
      rst_n16 = 1'b0; start16 = 1'b0; stop16 = 1'b0; valid16 = 1'b0;
      cyc16(0, 0, 0);
      cyc16(0, 0, 0);
      zero16("reset");
`ifdef FFT_TW_SCHED_ERR_EN
      chk("err16_reset", err16, 0);
`endif
      rst_n16 = 1'b1;
      cyc16(1, 0, 0);
      chk("busy16_start", bz16, 1);
      for (int i = 0; i < 16; i++) cyc16(0, 0, 1);
      for (int i = 0; i < 32; i++) cyc16(0, 0, (i % 2) == 0);
      // Frame 2: stop at ctr 5, frame still runs to 15.
      for (int i = 0; i < 16; i++) cyc16(0, (i == 5), 1);
      for (int i = 0; i < 8; i++) begin
         chk("drain_flush", fl16, 1);
         chk("drain_busy", bz16, 1);
         chk("drain_done", dn16, 0);
         cyc16(0, 0, 0);
      end
      chk("done_pulse", dn16, 1);
      chk("done_busy", bz16, 0);
      chk("done_flush", fl16, 0);
      m16 = MIdle;
      cyc16(0, 0, 0);
      chk("done_once", dn16, 0);
      chk("q16_empty_drain", q16.size(), 0);
      // Restart, then reset mid-frame right after ctr 9.
      cyc16(1, 0, 0);
      for (int i = 0; i < 10; i++) cyc16(0, 0, 1);
      rst_n16 = 1'b0;
      cyc16(0, 0, 1);
      zero16("mid_reset");
      chk("q16_empty_reset", q16.size(), 0);
      cyc16(0, 0, 0);
      zero16("mid_reset_hold");
      rst_n16 = 1'b1;
      cyc16(0, 0, 1);
      chk("idle_valid_busy", bz16, 0);
`ifdef FFT_TW_SCHED_ERR_EN
      chk("err16_idle_valid", err16, 1);
`endif
      // start+stop together in idle: stop ignored; then stop before first sample.
      cyc16(1, 1, 0);
      cyc16(0, 1, 0);
      for (int i = 0; i < 16; i++) cyc16(0, 0, 1);
      chk("stop_c0_flush", fl16, 1);
      for (int k = 0; k < 20 && dn16 !== 1'b1; k++) cyc16(0, 0, 0);
      chk("stop_c0_done_wait", dn16, 1);
      m16 = MIdle;
`ifdef FFT_TW_SCHED_ERR_EN
      chk("err16_sticky", err16, 1);
`endif
      rst_n16 = 1'b0;
      cyc16(0, 0, 0);
      zero16("final_reset");
`ifdef FFT_TW_SCHED_ERR_EN
      chk("err16_cleared", err16, 0);
`endif
      rst_n16 = 1'b1;
      cyc16(0, 0, 0);
      chk("q16_empty_end", q16.size(), 0);
   endtask

   task automatic seq64();
      rst_n64 = 1'b0; start64 = 1'b0; stop64 = 1'b0; valid64 = 1'b0;
      cyc64(0, 0);
      cyc64(0, 0);
      chk("reset64_ctr", ctr64, 0);
      chk("reset64_busy", bz64, 0);
      rst_n64 = 1'b1;
      cyc64(1, 0);
      for (int i = 0; i < 80; i++) cyc64(0, 1);
      cyc64(0, 0);
      cyc64(0, 0);
      chk("busy64_running", bz64, 1);
      chk("q64_empty_end", q64.size(), 0);
   endtask

   initial begin
      int t16[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
      int t64[16] = '{0, 0, 0, 0, 0, 8, 16, 24, 0, 4, 8, 12, 0, 12, 24, 36};
      for (int i = 0; i < 16; i++) tbl[i] = '{c: i, tw16: t16[i], tw64: t64[i]};
      fork
         seq16();
         seq64();
      join
      #20;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
